// File: rtl/hack_defs.sv
// Shared definitions for the Hack instruction fetch path.
//   HACK_AW       instruction address width (ROM space)
//   HACK_DW       instruction word width
//   RESET_PC      PC where fetch starts after reset
//   fetch_entry_t one queued instruction together with its PC
package hack_defs;

  localparam int unsigned HACK_AW = 15;
  localparam int unsigned HACK_DW = 16;

  localparam logic [HACK_AW-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [HACK_DW-1:0] instr;
    logic [HACK_AW-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched instructions. Has a registered head and a
// flush input.
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   flush      empties the queue; head keeps its last value
//   push       write push_data at the tail (the caller guarantees it is never full)
//   push_data  entry to enqueue
//   pop        drop the head entry; ignored when the queue is empty
//   head       oldest entry, registered; holds its value while empty
//   count      number of valid entries, 0..DEPTH
module fetch_fifo
  import hack_defs::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  entry_t        head_next;

  assign do_pop = pop && (count != '0);

  // head mirrors mem[rd_ptr] after every edge. It is kept in its own register
  // so that it can hold its last value once the queue drains. An entry pushed
  // into an empty queue, or into a queue whose only entry is popped in the
  // same cycle, bypasses storage and goes straight to head.
  always_comb begin
    head_next = head;
    if (do_pop) begin
      if (count > CW'(1)) begin
        head_next = mem[rd_ptr + PW'(1)];
      end else if (push) begin
        head_next = push_data;
      end
    end else if ((count == '0) && push) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(do_pop);
      head  <= head_next;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage between the program ROM and the Hack CPU.
// Sends ROM reads ahead of the CPU and queues each returned word with its PC.
// Queued words go to the CPU over a valid/ready handshake. A taken jump
// flushes the queue, discards words still in flight and redirects fetch.
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   rom_addr     ROM read address (current fetch PC)
//   rom_en       ROM read request this cycle
//   rom_data     ROM word, valid ROM_LAT cycles after its request
//   instr        head-of-queue instruction
//   instr_pc     PC of instr
//   instr_valid  instr/instr_pc are valid
//   instr_ready  CPU takes the head when instr_valid & instr_ready
//   jmp          taken jump from the CPU; overrides push, pop and issue
//   jmp_target   PC to redirect to
module fetch_queue
  import hack_defs::*;
#(
  parameter int unsigned AW      = HACK_AW,
  parameter int unsigned DW      = HACK_DW,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] rom_addr,
  output logic          rom_en,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_target
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(ROM_LAT + 1);
  localparam int unsigned SW = $clog2(DEPTH + ROM_LAT + 1);

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  // Tag for one outstanding ROM read.
  typedef struct packed {
    logic          valid;
    logic          epoch;
    logic [AW-1:0] pc;
  } tag_t;

  logic [AW-1:0] fetch_pc;
  logic          epoch;
  tag_t          pipe [ROM_LAT];
  tag_t          pipe_out;
  logic [IW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic          fifo_push;
  logic          fifo_pop;
  logic          issue;
  entry_t        fifo_head;
  entry_t        fifo_push_data;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + IW'(pipe[i].valid);
    end
  end

  assign pipe_out = pipe[ROM_LAT-1];

  // Credit rule: every outstanding read has a reserved slot. A word leaving
  // the pipe is still counted in inflight, so count < DEPTH whenever it is
  // pushed.
  assign issue = !jmp && ((SW'(fifo_count) + SW'(inflight)) < SW'(DEPTH));

  // Jump clears the pipe valid bits, so the epoch compare is a second guard
  // against stale words. It also holds if the epoch bit wraps.
  assign fifo_push      = pipe_out.valid && (pipe_out.epoch == epoch) && !jmp;
  assign fifo_pop       = instr_valid && instr_ready && !jmp;
  assign fifo_push_data = '{instr: rom_data, pc: pipe_out.pc};

  // Internal state ignores issue while in reset. Only the port needs gating
  // so that rom_en is low during reset.
  assign rom_en   = issue && reset;
  assign rom_addr = fetch_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= AW'(RESET_PC);
      epoch    <= 1'b0;
    end else if (jmp) begin
      fetch_pc <= jmp_target;
      epoch    <= ~epoch;
    end else if (issue) begin
      fetch_pc <= fetch_pc + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else if (jmp) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{valid: issue, epoch: epoch, pc: fetch_pc};
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (jmp),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign instr_valid = (fifo_count != '0);
  assign instr       = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue. A registered ROM model returns 16'h1000 + address.
// The expected stream is program order: it restarts at 0 after reset and at
// the target after a jump, and is kept in a scoreboard queue. A monitor
// checks each handshake against that queue and also checks redirect latency,
// back-to-back delivery, rom_en gating, reset outputs and FIFO overflow.
module tb_fetch_queue;
  import hack_defs::*;

  localparam int unsigned AW      = 15;
  localparam int unsigned DW      = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ROM_LAT = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          rom_en;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          jmp = 1'b0;
  logic [AW-1:0] jmp_target = '0;

  always #5 clk = ~clk;

  fetch_queue #(
    .AW      (AW),
    .DW      (DW),
    .DEPTH   (DEPTH),
    .ROM_LAT (ROM_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rom_addr    (rom_addr),
    .rom_en      (rom_en),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jmp         (jmp),
    .jmp_target  (jmp_target)
  );

  // Registered-output ROM, ROM[i] = 16'h1000 + i.
  always @(posedge clk) begin
    if (rom_en) rom_data <= 16'h1000 + 16'(rom_addr);
  end

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t          exp_q [$];
  logic [AW-1:0] next_pc = '0;
  int unsigned   errors = 0;
  int unsigned   checks = 0;

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{instr: 16'h1000 + 16'(next_pc), pc: next_pc});
      next_pc = next_pc + 1'b1;
    end
  endtask

  task automatic redirect(input logic [AW-1:0] pc);
    exp_q.delete();
    next_pc = pc;
    top_up();
  endtask

  // One clock cycle of stimulus, driven at the falling edge.
  task automatic step(input logic rdy, input logic j, input logic [AW-1:0] tgt, input logic rst_n);
    @(negedge clk);
    reset       = rst_n;
    instr_ready = rdy;
    jmp         = j;
    jmp_target  = tgt;
    if (!rst_n) redirect('0);
    else if (j) redirect(tgt);
    else top_up();
  endtask

  // Monitor: samples 2 time units after the falling edge. Inputs and outputs
  // are stable then and describe the transfer at the next rising edge.
  initial begin : monitor
    int unsigned age;
    bit          ready_run;
    exp_t        e;
    age = 0;
    ready_run = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        checks++;
        if ({instr_valid, rom_en, instr, instr_pc, rom_addr} != '0) begin
          errors++;
          $display("FAIL reset_outputs: valid=%b rom_en=%b instr=%h pc=%h rom_addr=%h, required all 0",
                   instr_valid, rom_en, instr, instr_pc, rom_addr);
        end
        age = 0;
        ready_run = 1'b1;
      end else begin
        if (age <= ROM_LAT) begin
          checks++;
          if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid: age=%0d valid=%b, required 0", age, instr_valid);
          end
        end else if (ready_run) begin
          checks++;
          if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL bubble: age=%0d valid=%b, required 1", age, instr_valid);
          end
        end
        if (jmp) begin
          checks++;
          if (rom_en !== 1'b0) begin
            errors++;
            $display("FAIL rom_en_on_jmp: rom_en=%b, required 0", rom_en);
          end
        end
        checks++;
        if (dut.fifo_push && (dut.fifo_count == DEPTH)) begin
          errors++;
          $display("FAIL overflow: push=%b count=%0d, required no push at count %0d",
                   dut.fifo_push, dut.fifo_count, DEPTH);
        end
        if (instr_valid && instr_ready && !jmp) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got pc=%h, required no delivery", instr_pc);
          end else begin
            e = exp_q.pop_front();
            if ((instr !== e.instr) || (instr_pc !== e.pc)) begin
              errors++;
              $display("FAIL data: got pc=%h instr=%h, required pc=%h instr=%h",
                       instr_pc, instr, e.pc, e.instr);
            end
          end
        end
        if (jmp) begin
          age = 0;
          ready_run = 1'b1;
        end else begin
          if (age < 1000) age++;
          ready_run = ready_run && instr_ready;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned stall_left;
    bit          rdy;
    bit          j;
    bit          rst_n;
    logic [AW-1:0] tgt;

    // 1: reset release with continuous consume.
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);

    // 2: CPU stalled; queue fills to DEPTH and issue stops.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1);
    #1;
    checks++;
    if ((rom_en !== 1'b0) || (dut.fifo_count != DEPTH)) begin
      errors++;
      $display("FAIL stall_full: rom_en=%b count=%0d, required rom_en=0 count=%0d",
               rom_en, dut.fifo_count, DEPTH);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b1);

    // 3: jump with 2 words queued and 1 in flight.
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 15'd400, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);

    // 4: back-to-back jumps; only the last target survives.
    step(1'b1, 1'b1, 15'd10, 1'b1);
    step(1'b1, 1'b1, 15'd20, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);

    // 5: fetch PC wraps at the top of ROM space.
    step(1'b1, 1'b1, 15'h7FFE, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);

    // 6: reset pulse mid-stream.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Random traffic: stalls, jumps near the wrap point, occasional resets.
    stall_left = 0;
    for (int i = 0; i < 2000; i++) begin
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 99) < 75);
        if ($urandom_range(0, 49) == 0) stall_left = $urandom_range(3, 12);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      j     = rst_n && ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) tgt = 15'h7FFC + 15'($urandom_range(0, 3));
      else tgt = 15'($urandom);
      step(rdy, j, tgt, rst_n);
    end

    step(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
